mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have no parameters; all widths come from the shared defines file.
REQ-002 SHALL have a single clock domain and a synchronous, active-high reset:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have these pipeline ports:
- ex_to_mem_bus  in  `EX_TO_MEM_BUS_WIDTH (140)  {mem_ext_op[2:0], rf_we, rf_wsel[2:0], pc4, ext, wb_reg[4:0], alu_c, csr_rdata}.
- ex_to_mem_valid  in  1  upstream bus valid.
- wb_allow_in  in  1  WB can accept this cycle.
- mem_allow_in  out  1  MEM can accept this cycle.
- mem_to_wb_valid  out  1  MEM output valid.
- mem_to_wb_bus  out  `MEM_TO_WB_BUS_WIDTH (38)  {rf_we, wb_reg, rf_wdata}.
- mem_to_id_bus  out  `MEM_TO_ID_BUS_WIDTH (39)  {mem_valid, rf_we, wb_reg, rf_wdata}, bypass to ID.
REQ-004 SHALL have these data-memory ports:
- dram_rdata  in  32  read word at the word address issued by EX.
- dram_rvalid  in  1  dram_rdata valid; may arrive 1..N cycles after the load enters MEM.

Function
REQ-005 SHALL capture ex_to_mem_bus into mem_regs on a rising edge when mem_allow_in && ex_to_mem_valid.
REQ-006 SHALL update mem_valid as follows:
- rst -> 0.
- else if mem_allow_in -> ex_to_mem_valid.
REQ-007 SHALL treat the instruction as a load (is_ld) iff rf_wsel == `WB_MEM.
REQ-008 SHALL use a load FSM with states IDLE, WAIT, HOLD:
- IDLE->WAIT: a valid load is captured and dram_rvalid is low in the cycle after capture.
- WAIT->HOLD: dram_rvalid=1 && !wb_allow_in; latch dram_rdata into rdata_buf.
- WAIT->IDLE: dram_rvalid=1 && wb_allow_in.
- HOLD->IDLE: wb_allow_in=1.
REQ-009 SHALL compute mem_ready_go = !is_ld || dram_rvalid || state==HOLD.
REQ-010 SHALL assign mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in), and mem_to_wb_valid = mem_valid && mem_ready_go.
REQ-011 SHALL take the load word from rdata_buf in HOLD, else from dram_rdata.
REQ-012 SHALL select the byte/half lane by alu_c[1:0] and extend per mem_ext_op:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: whole word.
REQ-013 SHALL select rf_wdata by rf_wsel: ALU->alu_c, EXT->ext, PC4->pc4, MEM->extended load, CSR->csr_rdata, other->0.
REQ-014 SHALL drive mem_to_id_bus every cycle:
- mem_valid field = mem_valid && mem_ready_go, so ID stalls on an unfinished load rather than forwarding it.
REQ-015 SHALL ignore dram_rvalid in IDLE when no load is pending, with no state change.
REQ-016 SHALL accept a back-to-back load in the same edge that the previous load leaves WAIT/HOLD, entering WAIT directly if dram_rvalid is low.
REQ-017 SHALL hold all mem_regs fields and rdata_buf while mem_valid && !mem_allow_in.

Reset
REQ-018 SHALL on rst:
- state -> IDLE, mem_valid -> 0, rdata_buf -> 0.
- therefore mem_to_wb_valid = 0 and the mem_to_id_bus valid bit = 0 in the next cycle.
- mem_regs are not reset; payload is don't-care while invalid.
REQ-019 SHALL abandon a load pending in WAIT when rst is asserted, with no write reaching WB.

Configuration
REQ-020 SHALL, with MEM_MISALIGN_EXC_EN defined:
- flag LH/LHU with alu_c[0]=1, or LW with alu_c[1:0]!=0, as misaligned.
- drop rf_we to 0 for that instruction.
- add output mem_excp (1 bit, = mem_to_wb_valid && misaligned) and mem_excp_badaddr (32 bits, = alu_c).
REQ-021 SHALL, without MEM_MISALIGN_EXC_EN, ignore misaligned address bits beyond lane select, omit both ports, and never suppress rf_we.

Structure
REQ-022 SHALL place the following in defines.v:
- `MEM_EXT_OP_WIDTH.
- MEM_EXT_LB/LBU/LH/LHU/LW codes 0..4.
- WB_* codes.
- `MEM_TO_WB_BUS_WIDTH and `MEM_TO_ID_BUS_WIDTH.
- load FSM state codes.
REQ-023 SHALL implement the lane select and extension as sub-module load_ext (inputs: word, addr[1:0], op; output: 32-bit result), purely combinational.

Verification
REQ-024 SHALL cover: ALU op, alu_c=0x1234, wb_allow_in=1 -> next cycle mem_to_wb_bus rf_wdata=0x1234, mem_to_wb_valid=1.
REQ-025 SHALL cover: LB at addr 0x...3, dram_rdata=0x80FF_0000 returned the same cycle -> rf_wdata=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-026 SHALL cover: LH at addr 0x...2, dram_rvalid delayed 3 cycles -> mem_allow_in=0 and ID valid bit=0 for 3 cycles; then rf_wdata = sign-extended upper half.
REQ-027 SHALL cover: LW with rvalid while wb_allow_in=0 for 2 cycles -> HOLD; output stays the buffered word even after dram_rdata changes.
REQ-028 SHALL cover: rst asserted during WAIT -> next cycle state=IDLE, mem_to_wb_valid=0; a later rvalid is ignored.
REQ-029 SHALL cover, with MEM_MISALIGN_EXC_EN: LW at 0x1002 -> mem_excp=1, badaddr=0x1002, rf_we=0; without the macro -> rf_we=1, no exception.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and bus layouts for the MEM pipeline stage.
// The `define block doubles as the legacy defines file for other pipeline stages.
`ifndef MEM_STAGE_DEFINES_DONE
`define MEM_STAGE_DEFINES_DONE
`define MEM_EXT_OP_WIDTH     3
`define MEM_EXT_LB           3'd0
`define MEM_EXT_LBU          3'd1
`define MEM_EXT_LH           3'd2
`define MEM_EXT_LHU          3'd3
`define MEM_EXT_LW           3'd4
`define WB_ALU               3'd0
`define WB_EXT               3'd1
`define WB_PC4               3'd2
`define WB_MEM               3'd3
`define WB_CSR               3'd4
`define EX_TO_MEM_BUS_WIDTH  140
`define MEM_TO_WB_BUS_WIDTH  38
`define MEM_TO_ID_BUS_WIDTH  39
`define LD_ST_IDLE           2'd0
`define LD_ST_WAIT           2'd1
`define LD_ST_HOLD           2'd2
`endif

package mem_stage_pkg;

    localparam int EX_TO_MEM_W = `EX_TO_MEM_BUS_WIDTH;
    localparam int MEM_TO_WB_W = `MEM_TO_WB_BUS_WIDTH;
    localparam int MEM_TO_ID_W = `MEM_TO_ID_BUS_WIDTH;
    localparam int EXT_OP_W    = `MEM_EXT_OP_WIDTH;

    localparam logic [EXT_OP_W-1:0] MEM_EXT_LB  = `MEM_EXT_LB;
    localparam logic [EXT_OP_W-1:0] MEM_EXT_LBU = `MEM_EXT_LBU;
    localparam logic [EXT_OP_W-1:0] MEM_EXT_LH  = `MEM_EXT_LH;
    localparam logic [EXT_OP_W-1:0] MEM_EXT_LHU = `MEM_EXT_LHU;
    localparam logic [EXT_OP_W-1:0] MEM_EXT_LW  = `MEM_EXT_LW;

    localparam logic [2:0] WB_ALU = `WB_ALU;
    localparam logic [2:0] WB_EXT = `WB_EXT;
    localparam logic [2:0] WB_PC4 = `WB_PC4;
    localparam logic [2:0] WB_MEM = `WB_MEM;
    localparam logic [2:0] WB_CSR = `WB_CSR;

    localparam logic [1:0] LD_ST_IDLE = `LD_ST_IDLE;
    localparam logic [1:0] LD_ST_WAIT = `LD_ST_WAIT;
    localparam logic [1:0] LD_ST_HOLD = `LD_ST_HOLD;

    // Field order matches the EX bus, MSB first.
    typedef struct packed {
        logic [EXT_OP_W-1:0] mem_ext_op;
        logic                rf_we;
        logic [2:0]          rf_wsel;
        logic [31:0]         pc4;
        logic [31:0]         ext;
        logic [4:0]          wb_reg;
        logic [31:0]         alu_c;
        logic [31:0]         csr_rdata;
    } ex_to_mem_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  wb_reg;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    function automatic logic is_misaligned(input logic [EXT_OP_W-1:0] op,
                                           input logic [1:0] addr);
        logic mis;
        mis = 1'b0;
        if ((op == MEM_EXT_LH) || (op == MEM_EXT_LHU)) begin
            mis = addr[0];
        end else if (op == MEM_EXT_LW) begin
            mis = (addr != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: picks the byte/half lane of a loaded word and sign/zero extends it.
// Purely combinational.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0]         word_i,
    input  logic [1:0]          addr_i,
    input  logic [EXT_OP_W-1:0] op_i,
    output logic [31:0]         result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        result_o = word_i;
        case (op_i)
            MEM_EXT_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_EXT_LBU: result_o = {24'd0, byte_sel};
            MEM_EXT_LH:  result_o = {{16{half_sel[15]}}, half_sel};
            MEM_EXT_LHU: result_o = {16'd0, half_sel};
            default:     result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data, forms write-back.
// Optional misaligned-load exception: define MEM_MISALIGN_EXC_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
    input  logic                   ex_to_mem_valid,
    input  logic                   wb_allow_in,
    output logic                   mem_allow_in,
    output logic                   mem_to_wb_valid,
    output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_W-1:0] mem_to_id_bus,
    input  logic [31:0]            dram_rdata,
    input  logic                   dram_rvalid,
`ifdef MEM_MISALIGN_EXC_EN
    output logic                   mem_excp,
    output logic [31:0]            mem_excp_badaddr,
`endif
    output logic [1:0]             dbg_ld_state_o
);

    // Handshake: an instruction moves MEM->WB on an edge where mem_to_wb_valid
    // and wb_allow_in are both high; EX->MEM moves when ex_to_mem_valid and
    // mem_allow_in are both high. Payload is held stable while stalled.

    ex_to_mem_t  mem_regs_q;
    logic        mem_valid_q;
    logic [1:0]  state_q, state_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        is_ld;
    logic        ld_active;
    logic        mem_ready_go;
    logic [31:0] ld_word;
    logic [31:0] ld_result;
    logic [31:0] rf_wdata;
    logic        rf_we_out;
    mem_to_wb_t  wb_pkt;

    always_ff @(posedge clk) begin
        if (mem_allow_in && ex_to_mem_valid) begin
            mem_regs_q <= ex_to_mem_t'(ex_to_mem_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
        end else if (mem_allow_in) begin
            mem_valid_q <= ex_to_mem_valid;
        end
    end

    assign is_ld     = (mem_regs_q.rf_wsel == WB_MEM);
    assign ld_active = mem_valid_q && is_ld;

    // IDLE also serves the first cycle of a freshly captured (or back-to-back) load.
    always_comb begin
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            LD_ST_IDLE, LD_ST_WAIT: begin
                if (!ld_active) begin
                    state_d = LD_ST_IDLE;
                end else if (!dram_rvalid) begin
                    state_d = LD_ST_WAIT;
                end else if (wb_allow_in) begin
                    state_d = LD_ST_IDLE;
                end else begin
                    state_d     = LD_ST_HOLD;
                    rdata_buf_d = dram_rdata;
                end
            end
            LD_ST_HOLD: begin
                if (wb_allow_in) begin
                    state_d = LD_ST_IDLE;
                end
            end
            default: state_d = LD_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LD_ST_IDLE;
            rdata_buf_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign mem_ready_go    = !is_ld || dram_rvalid || (state_q == LD_ST_HOLD);
    assign mem_allow_in    = !mem_valid_q || (mem_ready_go && wb_allow_in);
    assign mem_to_wb_valid = mem_valid_q && mem_ready_go;

    assign ld_word = (state_q == LD_ST_HOLD) ? rdata_buf_q : dram_rdata;

    load_ext u_load_ext (
        .word_i   (ld_word),
        .addr_i   (mem_regs_q.alu_c[1:0]),
        .op_i     (mem_regs_q.mem_ext_op),
        .result_o (ld_result)
    );

    always_comb begin
        rf_wdata = 32'd0;
        case (mem_regs_q.rf_wsel)
            WB_ALU:  rf_wdata = mem_regs_q.alu_c;
            WB_EXT:  rf_wdata = mem_regs_q.ext;
            WB_PC4:  rf_wdata = mem_regs_q.pc4;
            WB_MEM:  rf_wdata = ld_result;
            WB_CSR:  rf_wdata = mem_regs_q.csr_rdata;
            default: rf_wdata = 32'd0;
        endcase
    end

`ifdef MEM_MISALIGN_EXC_EN
    logic misaligned;
    assign misaligned       = is_ld && is_misaligned(mem_regs_q.mem_ext_op,
                                                     mem_regs_q.alu_c[1:0]);
    assign rf_we_out        = mem_regs_q.rf_we && !misaligned;
    assign mem_excp         = mem_to_wb_valid && misaligned;
    assign mem_excp_badaddr = mem_regs_q.alu_c;
`else
    assign rf_we_out = mem_regs_q.rf_we;
`endif

    assign wb_pkt.rf_we    = rf_we_out;
    assign wb_pkt.wb_reg   = mem_regs_q.wb_reg;
    assign wb_pkt.rf_wdata = rf_wdata;

    assign mem_to_wb_bus  = wb_pkt;
    // ID must stall on an unfinished load, so the bypass valid includes ready_go.
    assign mem_to_id_bus  = {mem_valid_q && mem_ready_go, wb_pkt};
    assign dbg_ld_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-transaction results,
// plus hand-written sequences for delayed data, WB stall, and reset during a load.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                   clk;
    logic                   rst;
    ex_to_mem_t             ex_bus;
    logic                   ex_valid;
    logic                   wb_allow_in;
    logic                   mem_allow_in;
    logic                   mem_to_wb_valid;
    logic [MEM_TO_WB_W-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_W-1:0] mem_to_id_bus;
    logic [31:0]            dram_rdata;
    logic                   dram_rvalid;
    logic [1:0]             dbg_state;
`ifdef MEM_MISALIGN_EXC_EN
    logic                   mem_excp;
    logic [31:0]            mem_excp_badaddr;
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_to_mem_bus   (ex_bus),
        .ex_to_mem_valid (ex_valid),
        .wb_allow_in     (wb_allow_in),
        .mem_allow_in    (mem_allow_in),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus),
        .dram_rdata      (dram_rdata),
        .dram_rvalid     (dram_rvalid),
`ifdef MEM_MISALIGN_EXC_EN
        .mem_excp        (mem_excp),
        .mem_excp_badaddr(mem_excp_badaddr),
`endif
        .dbg_ld_state_o  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [2:0]  wsel;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] alu_c;
        logic [31:0] pc4;
        logic [31:0] ext;
        logic [31:0] csr;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        mis;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ex_to_mem_t mk(input logic [2:0] op, input logic [2:0] wsel,
                                      input logic [4:0] wreg, input logic [31:0] alu_c);
        ex_to_mem_t p;
        p.mem_ext_op = op;
        p.rf_we      = 1'b1;
        p.rf_wsel    = wsel;
        p.pc4        = 32'h0000_0100;
        p.ext        = 32'h0000_0200;
        p.wb_reg     = wreg;
        p.alu_c      = alu_c;
        p.csr_rdata  = 32'h0000_0300;
        return p;
    endfunction

    // Presents one instruction; returns at the negedge after it was captured.
    task automatic send(input ex_to_mem_t p);
        @(negedge clk);
        ex_bus      = p;
        ex_valid    = 1'b1;
        dram_rvalid = 1'b0;
        @(negedge clk);
        ex_valid    = 1'b0;
    endtask

    initial begin
        mem_to_wb_t wb;
        ex_to_mem_t p;

        vecs[0]  = '{"alu",     3'd0, WB_ALU, 1'b1, 5'd1,  32'h0000_1234, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_1800, 32'h0,          32'h0000_1234, 1'b0};
        vecs[1]  = '{"ext",     3'd0, WB_EXT, 1'b1, 5'd2,  32'h0000_0010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_1800, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{"pc4",     3'd0, WB_PC4, 1'b1, 5'd3,  32'h0000_0010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_1800, 32'h0,          32'h8000_0004, 1'b0};
        vecs[3]  = '{"csr",     3'd0, WB_CSR, 1'b0, 5'd4,  32'h0000_0010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_1800, 32'h0,          32'h0000_1800, 1'b0};
        vecs[4]  = '{"wsel7",   3'd0, 3'd7,   1'b1, 5'd5,  32'h0000_0010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_1800, 32'h0,          32'h0000_0000, 1'b0};
        vecs[5]  = '{"lb_a3",   MEM_EXT_LB,  WB_MEM, 1'b1, 5'd6,  32'h0000_1003, 32'h0, 32'h0, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0};
        vecs[6]  = '{"lbu_a3",  MEM_EXT_LBU, WB_MEM, 1'b1, 5'd7,  32'h0000_1003, 32'h0, 32'h0, 32'h0, 32'h80FF_0000, 32'h0000_0080, 1'b0};
        vecs[7]  = '{"lb_a1",   MEM_EXT_LB,  WB_MEM, 1'b1, 5'd8,  32'h0000_1001, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0056, 1'b0};
        vecs[8]  = '{"lh_a0",   MEM_EXT_LH,  WB_MEM, 1'b1, 5'd9,  32'h0000_2000, 32'h0, 32'h0, 32'h0, 32'h1234_8001, 32'hFFFF_8001, 1'b0};
        vecs[9]  = '{"lhu_a2",  MEM_EXT_LHU, WB_MEM, 1'b1, 5'd10, 32'h0000_2002, 32'h0, 32'h0, 32'h0, 32'hFEDC_1234, 32'h0000_FEDC, 1'b0};
        vecs[10] = '{"lw_a0",   MEM_EXT_LW,  WB_MEM, 1'b1, 5'd11, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0};
        vecs[11] = '{"lw_mis",  MEM_EXT_LW,  WB_MEM, 1'b1, 5'd12, 32'h0000_1002, 32'h0, 32'h0, 32'h0, 32'h1111_2222, 32'h1111_2222, 1'b1};
        vecs[12] = '{"lbu_a2",  MEM_EXT_LBU, WB_MEM, 1'b1, 5'd13, 32'h0000_0002, 32'h0, 32'h0, 32'h0, 32'hAABB_CCDD, 32'h0000_00BB, 1'b0};

        rst = 1'b1; ex_valid = 1'b0; wb_allow_in = 1'b1;
        dram_rvalid = 1'b0; dram_rdata = 32'h0;
        ex_bus = mk(3'd0, WB_ALU, 5'd0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wb_valid", {31'd0, mem_to_wb_valid}, 32'd0);
        check("rst_id_valid", {31'd0, mem_to_id_bus[38]}, 32'd0);
        check("rst_allow_in", {31'd0, mem_allow_in}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, {30'd0, LD_ST_IDLE});

        // Table: data returned in the first cycle in MEM, WB always ready.
        for (int i = 0; i < 13; i++) begin
            p.mem_ext_op = vecs[i].op;
            p.rf_we      = vecs[i].we;
            p.rf_wsel    = vecs[i].wsel;
            p.pc4        = vecs[i].pc4;
            p.ext        = vecs[i].ext;
            p.wb_reg     = vecs[i].wreg;
            p.alu_c      = vecs[i].alu_c;
            p.csr_rdata  = vecs[i].csr;
            send(p);
            dram_rvalid = 1'b1;
            dram_rdata  = vecs[i].rdata;
            #1;
            wb = mem_to_wb_t'(mem_to_wb_bus);
            check({vecs[i].name, "_valid"}, {31'd0, mem_to_wb_valid}, 32'd1);
            check({vecs[i].name, "_wdata"}, wb.rf_wdata, vecs[i].exp_wdata);
            check({vecs[i].name, "_we"}, {31'd0, wb.rf_we},
                  {31'd0, vecs[i].we && !(MIS_EN && vecs[i].mis)});
            check({vecs[i].name, "_wreg"}, {27'd0, wb.wb_reg}, {27'd0, vecs[i].wreg});
            check({vecs[i].name, "_id"}, {mem_to_id_bus[38], mem_to_id_bus[30:0]},
                  {1'b1, vecs[i].exp_wdata[30:0]});
`ifdef MEM_MISALIGN_EXC_EN
            check({vecs[i].name, "_excp"}, {31'd0, mem_excp}, {31'd0, vecs[i].mis});
            if (vecs[i].mis) check({vecs[i].name, "_badaddr"}, mem_excp_badaddr, vecs[i].alu_c);
`endif
            @(negedge clk);
            dram_rvalid = 1'b0;
        end
        #1;
        check("tbl_end_state", {30'd0, dbg_state}, {30'd0, LD_ST_IDLE});
        check("tbl_end_valid", {31'd0, mem_to_wb_valid}, 32'd0);

        // LH at offset 2 with data 3 cycles late; an ALU op follows back-to-back.
        send(mk(MEM_EXT_LH, WB_MEM, 5'd20, 32'h0000_5002));
        for (int k = 0; k < 3; k++) begin
            dram_rvalid = 1'b0;
            dram_rdata  = 32'h0BAD_0BAD;
            #1;
            check("lh_wait_allow", {31'd0, mem_allow_in}, 32'd0);
            check("lh_wait_id", {31'd0, mem_to_id_bus[38]}, 32'd0);
            check("lh_wait_wbv", {31'd0, mem_to_wb_valid}, 32'd0);
            if (k > 0) check("lh_wait_state", {30'd0, dbg_state}, {30'd0, LD_ST_WAIT});
            @(negedge clk);
        end
        dram_rvalid = 1'b1;
        dram_rdata  = 32'h8765_4321;
        ex_bus      = mk(3'd0, WB_ALU, 5'd21, 32'h0000_55AA);
        ex_valid    = 1'b1;
        #1;
        wb = mem_to_wb_t'(mem_to_wb_bus);
        check("lh_done_valid", {31'd0, mem_to_wb_valid}, 32'd1);
        check("lh_done_wdata", wb.rf_wdata, 32'hFFFF_8765);
        check("lh_done_allow", {31'd0, mem_allow_in}, 32'd1);
        @(negedge clk);
        ex_valid    = 1'b0;
        dram_rvalid = 1'b0;
        #1;
        wb = mem_to_wb_t'(mem_to_wb_bus);
        check("b2b_valid", {31'd0, mem_to_wb_valid}, 32'd1);
        check("b2b_wdata", wb.rf_wdata, 32'h0000_55AA);
        check("b2b_wreg", {27'd0, wb.wb_reg}, 32'd21);
        @(negedge clk);

        // LW whose data arrives while WB is stalled for two cycles.
        send(mk(MEM_EXT_LW, WB_MEM, 5'd22, 32'h0000_3000));
        wb_allow_in = 1'b0;
        dram_rvalid = 1'b1;
        dram_rdata  = 32'hA5A5_5A5A;
        #1;
        check("hold_c0_valid", {31'd0, mem_to_wb_valid}, 32'd1);
        check("hold_c0_allow", {31'd0, mem_allow_in}, 32'd0);
        @(negedge clk);
        dram_rvalid = 1'b0;
        dram_rdata  = 32'hFFFF_0000;
        #1;
        wb = mem_to_wb_t'(mem_to_wb_bus);
        check("hold_c1_state", {30'd0, dbg_state}, {30'd0, LD_ST_HOLD});
        check("hold_c1_valid", {31'd0, mem_to_wb_valid}, 32'd1);
        check("hold_c1_wdata", wb.rf_wdata, 32'hA5A5_5A5A);
        check("hold_c1_allow", {31'd0, mem_allow_in}, 32'd0);
        @(negedge clk);
        wb_allow_in = 1'b1;
        #1;
        wb = mem_to_wb_t'(mem_to_wb_bus);
        check("hold_c2_wdata", wb.rf_wdata, 32'hA5A5_5A5A);
        check("hold_c2_allow", {31'd0, mem_allow_in}, 32'd1);
        @(negedge clk);
        #1;
        check("hold_exit_state", {30'd0, dbg_state}, {30'd0, LD_ST_IDLE});
        check("hold_exit_valid", {31'd0, mem_to_wb_valid}, 32'd0);

        // Reset while a load waits in WAIT; the late data must be ignored.
        send(mk(MEM_EXT_LW, WB_MEM, 5'd23, 32'h0000_4000));
        dram_rvalid = 1'b0;
        @(negedge clk);
        #1;
        check("rstw_state", {30'd0, dbg_state}, {30'd0, LD_ST_WAIT});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_after_state", {30'd0, dbg_state}, {30'd0, LD_ST_IDLE});
        check("rstw_after_valid", {31'd0, mem_to_wb_valid}, 32'd0);
        check("rstw_after_id", {31'd0, mem_to_id_bus[38]}, 32'd0);
        dram_rvalid = 1'b1;
        dram_rdata  = 32'h1357_9BDF;
        #1;
        check("rstw_late_valid", {31'd0, mem_to_wb_valid}, 32'd0);
        @(negedge clk);
        dram_rvalid = 1'b0;
        #1;
        check("rstw_late_state", {30'd0, dbg_state}, {30'd0, LD_ST_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
